// File: rtl/denise_pkg.sv
// Purpose: shared register addresses, CLXDAT bit positions and CLXCON layout for the collision block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package denise_pkg;

  // Full 9-bit register offsets; the bus carries bits [8:1] only.
  localparam logic [8:0] CLXDAT  = 9'h00E;
  localparam logic [8:0] CLXCON  = 9'h098;
  localparam logic [8:0] CLXCON2 = 9'h10E;

  // CLXDAT bit positions. Odd/even plane vs sprite-group bits are base + group.
  localparam int CLX_BPE_BPO  = 0;
  localparam int CLX_BPO_SPG  = 1;
  localparam int CLX_BPE_SPG  = 5;
  localparam int CLX_SP0_SP1  = 9;
  localparam int CLX_SP0_SP2  = 10;
  localparam int CLX_SP0_SP3  = 11;
  localparam int CLX_SP1_SP2  = 12;
  localparam int CLX_SP1_SP3  = 13;
  localparam int CLX_SP2_SP3  = 14;

  // ensp[0] = ENSP1 .. ensp[3] = ENSP7; enbp/mvbp[0] = plane 1 .. [5] = plane 6.
  typedef struct packed {
    logic [3:0] ensp;
    logic [5:0] enbp;
    logic [5:0] mvbp;
  } clxcon_t;

  function automatic logic reg_hit(input logic [8:1] addr, input logic [8:0] reg_addr);
    logic [8:0] a;
    a = reg_addr;
    return addr == a[8:1];
  endfunction

endpackage

// File: rtl/denise_collision_if.sv
// Purpose: chip register bus slice seen by the collision block (address, write data, read data).
// Latency: read data is combinational from the address; writes land on the next pixel-enabled edge.
// Backpressure: none; every access completes in the cycle it is presented.
interface denise_collision_if;
  logic [8:1]  reg_address_in;
  logic [15:0] data_in;
  logic [15:0] data_out;

  modport master (output reg_address_in, output data_in, input data_out);
  modport slave  (input reg_address_in, input data_in, output data_out);
endinterface

// File: rtl/denise_collision_match.sv
// Purpose: plane-match for one parity (four planes): each enabled plane must equal its match bit.
// Latency: purely combinational.
// Backpressure: none.
// Ports: planes = current pixel bits, enbp = per-plane enables, mvbp = match values, hit = all enabled planes match.
module denise_collision_match (
  input  logic [3:0] planes,
  input  logic [3:0] enbp,
  input  logic [3:0] mvbp,
  output logic       hit
);

  // A disabled plane is a don't-care, so it always counts as matching.
  assign hit = &(~enbp | ~(planes ^ mvbp));

endmodule

// File: rtl/denise_collision.sv
// Purpose: Denise sprite/playfield collision detect: CLXCON(/CLXCON2) config, sticky CLXDAT with clear-on-read.
// Latency: a pixel hit at pixel-enabled edge N is visible on data_out after edge N; reads are combinational.
// Backpressure: none; register accesses and pixels are consumed every clk7_en cycle.
// Ports: clk/reset_n, clk7_en pixel enable, aga mode, bpldata[8:1] planes, nsprite flags, bus = register slice.
// Option: define MINIMIG_CLXCON2_EN to add the CLXCON2 register and compare planes 7/8.
module denise_collision
  import denise_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clk7_en,
  input  logic                aga,
  input  logic [8:1]          bpldata,
  input  logic [7:0]          nsprite,
  denise_collision_if.slave   bus
);

  clxcon_t     clxcon_q, clxcon_d;
  logic [14:0] clxdat_q, clxdat_d;
  logic [14:0] hits;
  logic [3:0]  sg;
  logic        rd, wr_con;
  logic        odd_hit, even_hit;
  logic [1:0]  ext_enbp, ext_mvbp;  // [0] = plane 7, [1] = plane 8

  assign rd     = reg_hit(bus.reg_address_in, CLXDAT);
  assign wr_con = reg_hit(bus.reg_address_in, CLXCON);

`ifdef MINIMIG_CLXCON2_EN
  logic [3:0] clxcon2_q, clxcon2_d;  // {ENBP8, ENBP7, MVBP8, MVBP7}
  logic       wr_con2;

  assign wr_con2 = aga & reg_hit(bus.reg_address_in, CLXCON2);

  always_comb begin
    clxcon2_d = clxcon2_q;
    if (clk7_en) begin
      // Any CLXCON write drops back to 6-plane compares.
      if (wr_con)       clxcon2_d = '0;
      else if (wr_con2) clxcon2_d = {bus.data_in[7:6], bus.data_in[1:0]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clxcon2_q <= '0;
    else          clxcon2_q <= clxcon2_d;
  end

  assign ext_enbp = clxcon2_q[3:2];
  assign ext_mvbp = clxcon2_q[1:0];
`else
  // Without CLXCON2 the aga strap has nothing to gate.
  logic unused_aga;
  assign unused_aga = aga;
  assign ext_enbp   = 2'b00;
  assign ext_mvbp   = 2'b00;
`endif

  denise_collision_match u_odd (
    .planes ({bpldata[7], bpldata[5], bpldata[3], bpldata[1]}),
    .enbp   ({ext_enbp[0], clxcon_q.enbp[4], clxcon_q.enbp[2], clxcon_q.enbp[0]}),
    .mvbp   ({ext_mvbp[0], clxcon_q.mvbp[4], clxcon_q.mvbp[2], clxcon_q.mvbp[0]}),
    .hit    (odd_hit)
  );

  denise_collision_match u_even (
    .planes ({bpldata[8], bpldata[6], bpldata[4], bpldata[2]}),
    .enbp   ({ext_enbp[1], clxcon_q.enbp[5], clxcon_q.enbp[3], clxcon_q.enbp[1]}),
    .mvbp   ({ext_mvbp[1], clxcon_q.mvbp[5], clxcon_q.mvbp[3], clxcon_q.mvbp[1]}),
    .hit    (even_hit)
  );

  always_comb begin
    hits = '0;
    sg   = '0;
    // Even sprite of each pair always counts; the odd one only when attached via ENSP.
    for (int g = 0; g < 4; g++) begin
      sg[g] = nsprite[2*g] | (clxcon_q.ensp[g] & nsprite[2*g+1]);
    end
    hits[CLX_BPE_BPO] = even_hit & odd_hit;
    for (int g = 0; g < 4; g++) begin
      hits[CLX_BPO_SPG + g] = odd_hit  & sg[g];
      hits[CLX_BPE_SPG + g] = even_hit & sg[g];
    end
    hits[CLX_SP0_SP1] = sg[0] & sg[1];
    hits[CLX_SP0_SP2] = sg[0] & sg[2];
    hits[CLX_SP0_SP3] = sg[0] & sg[3];
    hits[CLX_SP1_SP2] = sg[1] & sg[2];
    hits[CLX_SP1_SP3] = sg[1] & sg[3];
    hits[CLX_SP2_SP3] = sg[2] & sg[3];
  end

  always_comb begin
    clxcon_d = clxcon_q;
    clxdat_d = clxdat_q;
    if (clk7_en) begin
      if (wr_con) clxcon_d = clxcon_t'(bus.data_in);
      // Clear-on-read and a same-edge hit: the new hit survives for the next read.
      clxdat_d = (rd ? 15'd0 : clxdat_q) | hits;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clxcon_q <= '0;
      clxdat_q <= '0;
    end else begin
      clxcon_q <= clxcon_d;
      clxdat_q <= clxdat_d;
    end
  end

  // Zero when not addressed so the read bus can be OR-merged.
  assign bus.data_out = rd ? {1'b1, clxdat_q} : 16'h0000;

endmodule

// File: tb/tb_denise_collision.sv
module tb_denise_collision;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk7_en;
  logic       aga;
  logic [8:1] bpldata;
  logic [7:0] nsprite;

  denise_collision_if bus_if ();

  denise_collision dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk7_en (clk7_en),
    .aga     (aga),
    .bpldata (bpldata),
    .nsprite (nsprite),
    .bus     (bus_if)
  );

  always #18 clk = ~clk;

  localparam logic [8:1] A_DAT  = 8'h07;
  localparam logic [8:1] A_CON  = 8'h4C;
  localparam logic [8:1] A_CON2 = 8'h87;
  localparam logic [8:1] A_NONE = 8'h00;

`ifdef MINIMIG_CLXCON2_EN
  localparam logic [15:0] EXP_PLANE8 = 16'h8000;
`else
  localparam logic [15:0] EXP_PLANE8 = 16'h8001;
`endif

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic drive(input logic [8:1] a, input logic [15:0] d,
                       input logic [7:0] bpl, input logic [7:0] ns);
    bus_if.reg_address_in = a;
    bus_if.data_in        = d;
    bpldata               = bpl;
    nsprite               = ns;
  endtask

  task automatic pulse7();
    clk7_en = 1'b1;
    @(posedge clk);
    #1;
    clk7_en = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Expected value is queued with the stimulus; the observed value is captured after settling.
  task automatic look(input string nm, input logic [15:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
    obs_q.push_back(bus_if.data_out);
  endtask

  task automatic test_reset();
    logic [15:0] e, o;
    string nm;
    reset_n = 1'b0;
    aga     = 1'b0;
    clk7_en = 1'b0;
    drive(A_DAT, 16'h0000, 8'h00, 8'hFF);
    pulse7();
    look("rst_addressed", 16'h8000);
    drive(A_NONE, 16'h0000, 8'h00, 8'hFF);
    look("rst_unaddressed", 16'h0000);
    reset_n = 1'b1;
    drive(A_DAT, 16'h0000, 8'h00, 8'h00);
    look("post_rst", 16'h8000);
    pulse7();
    look("first_h0", 16'h8001);
    drive(A_DAT, 16'h0000, 8'hAA, 8'hFF);
    idle(); idle(); idle();
    look("no_en_hold", 16'h8001);
    drive(A_NONE, 16'h0000, 8'h00, 8'h00);
    look("unaddr_zero", 16'h0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: data_out=%h expected=%h", nm, o, e);
      end
    end
  endtask

  task automatic test_plane_sprite();
    logic [15:0] e, o;
    string nm;
    drive(A_CON, 16'h0FC0, 8'h00, 8'h00);
    pulse7();
    drive(A_DAT, 16'h0000, 8'h01, 8'h00);
    pulse7();
    look("clr_pre", 16'h8000);
    drive(A_NONE, 16'h0000, 8'h00, 8'h01);
    pulse7();
    drive(A_DAT, 16'h0000, 8'h01, 8'h00);
    look("hit_0_1_5", 16'h8023);
    pulse7();
    look("cleared", 16'h8000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: data_out=%h expected=%h", nm, o, e);
      end
    end
  endtask

  task automatic test_sprite_pairs();
    logic [15:0] e, o;
    string nm;
    drive(A_CON, 16'h0000, 8'h00, 8'h00);
    pulse7();
    drive(A_DAT, 16'h0000, 8'h00, 8'h00);
    pulse7();
    drive(A_NONE, 16'h0000, 8'h00, 8'h05);
    pulse7();
    drive(A_DAT, 16'h0000, 8'h00, 8'h00);
    look("pair_sg0_sg1", 16'h8267);
    pulse7();
    drive(A_NONE, 16'h0000, 8'h00, 8'h02);
    pulse7();
    drive(A_DAT, 16'h0000, 8'h00, 8'h00);
    look("ensp_off", 16'h8001);
    pulse7();
    drive(A_CON, 16'h1000, 8'h00, 8'h00);
    pulse7();
    drive(A_NONE, 16'h0000, 8'h00, 8'h06);
    pulse7();
    drive(A_DAT, 16'h0000, 8'h00, 8'h00);
    look("ensp_on", 16'h8267);
    pulse7();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: data_out=%h expected=%h", nm, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e, o;
    string nm;
    drive(A_DAT, 16'h0000, 8'h00, 8'h06);
    look("same_edge_old", 16'h8001);
    pulse7();
    look("same_edge_new", 16'h8267);
    drive(A_DAT, 16'h0000, 8'h00, 8'h00);
    pulse7();
    look("latest_only", 16'h8001);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: data_out=%h expected=%h", nm, o, e);
      end
    end
  endtask

  task automatic test_clxcon2();
    logic [15:0] e, o;
    string nm;
    aga = 1'b1;
    drive(A_CON2, 16'h00C0, 8'h00, 8'h00);
    pulse7();
    drive(A_CON, 16'h0FC0, 8'h00, 8'h00);
    pulse7();
    drive(A_DAT, 16'h0000, 8'h80, 8'h00);
    pulse7();
    look("clxcon2_cleared", 16'h8001);
    drive(A_DAT, 16'h0000, 8'h01, 8'h00);
    pulse7();
    drive(A_CON2, 16'h00C0, 8'h01, 8'h00);
    pulse7();
    drive(A_NONE, 16'h0000, 8'h80, 8'h00);
    pulse7();
    drive(A_DAT, 16'h0000, 8'h01, 8'h00);
    look("clxcon2_plane8", EXP_PLANE8);
    pulse7();
    drive(A_CON, 16'h0FC0, 8'h01, 8'h00);
    pulse7();
    aga = 1'b0;
    drive(A_CON2, 16'h00C0, 8'h01, 8'h00);
    pulse7();
    drive(A_NONE, 16'h0000, 8'h80, 8'h00);
    pulse7();
    drive(A_DAT, 16'h0000, 8'h01, 8'h00);
    look("aga0_ignored", 16'h8001);
    pulse7();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: data_out=%h expected=%h", nm, o, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] e, o;
    string nm;
    drive(A_NONE, 16'h0000, 8'h00, 8'hFF);
    pulse7();
    drive(A_DAT, 16'h0000, 8'h00, 8'h00);
    look("all_hits", 16'hFFFF);
    reset_n = 1'b0;
    look("async_clr", 16'h8000);
    idle();
    reset_n = 1'b1;
    drive(A_DAT, 16'h0000, 8'h01, 8'h00);
    pulse7();
    look("rst_clxcon", 16'h8001);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: data_out=%h expected=%h", nm, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plane_sprite();
    test_sprite_pairs();
    test_back_to_back();
    test_clxcon2();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
